line_follow_ctrl: RTL and testbench

- Parametrised successor to the six-sensor direction controller.
- Takes N_PAIRS left/right pairs of active-low line sensors and synchronises and debounces each bit independently.
- A registered state machine turns the debounced pattern into a 4-bit steering command for the motor-drive block.
- Adds over the previous generation: an enable input, a state output, a change strobe, and a corner timer that restarts whenever the pattern changes.

---
 rtl/line_follow_pkg.sv | 41 ++++
 rtl/line_follow_ctrl_sensor_debounce.sv | 53 +++++
 rtl/line_follow_ctrl.sv | 169 ++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// line_follow_pkg: shared state codes, steering command constants and the
// stable-pattern decoder used by line_follow_ctrl.
package line_follow_pkg;

  typedef enum logic [2:0] {
    ST_FOLLOW      = 3'd0,
    ST_VEER_L      = 3'd1,
    ST_VEER_R      = 3'd2,
    ST_TURN_L      = 3'd3,
    ST_TURN_R      = 3'd4,
    ST_CORNER_HOLD = 3'd5,
    ST_STOP        = 3'd6,
    ST_LOST        = 3'd7
  } lf_state_e;

  // dir[3:2] steer, dir[1:0] intensity
  localparam logic [3:0] DIR_PROCEED = 4'b0000;
  localparam logic [3:0] DIR_VEER_L  = 4'b0101;
  localparam logic [3:0] DIR_VEER_R  = 4'b1001;
  localparam logic [3:0] DIR_PIVOT_L = 4'b0111;
  localparam logic [3:0] DIR_PIVOT_R = 4'b1011;
  localparam logic [3:0] DIR_HARD_L  = 4'b0110;
  localparam logic [3:0] DIR_HARD_R  = 4'b1010;
  localparam logic [3:0] DIR_STOP    = 4'b1111;

  // Map the debounced pattern to a target state; front and corner are {L,R}.
  function automatic lf_state_e decode_pattern(input logic [1:0] front,
                                               input logic [1:0] corner,
                                               input logic       any_line);
    lf_state_e st;
    st = ST_CORNER_HOLD;
    if (!any_line)              st = ST_LOST;
    else if (front == 2'b11)    st = ST_FOLLOW;
    else if (front == 2'b10)    st = ST_VEER_L;
    else if (front == 2'b01)    st = ST_VEER_R;
    else if (corner == 2'b10)   st = ST_TURN_L;
    else if (corner == 2'b01)   st = ST_TURN_R;
    return st;
  endfunction

endpackage

// File: rtl/line_follow_ctrl_sensor_debounce.sv
// sensor_debounce: per-bit 2-flop synchroniser followed by inversion and an
// independent debounce counter per bit.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   i_raw_n   in   WIDTH raw active-low sensor bits
//   o_stable  out  WIDTH debounced line-detect bits (1 = line)
module sensor_debounce #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw_n,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_line;

  // Raw flops reset to the idle (no line) level so reset reads as "no line".
  assign w_line   = ~r_sync2;
  assign o_stable = r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
      // Count consecutive disagreeing samples; commit on the CYCLES-th one.
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (w_line[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(CYCLES - 1)) begin
          r_stable[i] <= w_line[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: debounces N_PAIRS left/right line-sensor pairs and turns
// the stable pattern into a registered 4-bit steering command.
// Optional feature macro: LOST_RECOVER_EN (timed hard-turn recovery in LOST;
// also adds the LOST_CYCLES parameter).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   enable      in   0 forces STOP
//   sensor_n    in   raw active-low sensors, bit 2k left / 2k+1 right of pair k
//   dir         out  [3:2] steer, [1:0] intensity
//   state       out  current FSM state code
//   stable      out  debounced line-detect vector (1 = line)
//   dir_change  out  one-cycle pulse when dir takes a new value
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int unsigned N_PAIRS         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 12_500_000,
  parameter int unsigned CORNER_CYCLES   = 50_000_000
`ifdef LOST_RECOVER_EN
  ,
  parameter int unsigned LOST_CYCLES     = 25_000_000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2*N_PAIRS-1:0] sensor_n,
  output logic [3:0]           dir,
  output logic [2:0]           state,
  output logic [2*N_PAIRS-1:0] stable,
  output logic                 dir_change
);

  localparam int unsigned SENSE_W  = 2 * N_PAIRS;
  localparam int unsigned F_IDX    = 2 * (N_PAIRS - 1);
  localparam int unsigned M_IDX    = 2 * (N_PAIRS - 2);
  localparam int unsigned CORNER_W = $clog2(CORNER_CYCLES + 1);

  logic [SENSE_W-1:0]  w_stable;
  logic [SENSE_W-1:0]  r_stable_q;
  logic                w_stable_chg;
  logic [1:0]          w_front;
  logic [1:0]          w_corner;
  lf_state_e           w_decoded;
  lf_state_e           r_state;
  lf_state_e           w_state_next;
  logic [3:0]          r_dir;
  logic [3:0]          w_dir_next;
  logic                r_dir_change;
  logic [CORNER_W-1:0] r_corner_cnt;
`ifdef LOST_RECOVER_EN
  localparam int unsigned LOST_W = $clog2(LOST_CYCLES + 1);
  logic [LOST_W-1:0]   r_lost_cnt;
`endif

  sensor_debounce #(
    .WIDTH  (SENSE_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_raw_n  (sensor_n),
    .o_stable (w_stable)
  );

  assign w_front      = {w_stable[F_IDX], w_stable[F_IDX+1]};
  assign w_corner     = {w_stable[M_IDX], w_stable[M_IDX+1]};
  assign w_decoded    = decode_pattern(w_front, w_corner, |w_stable);
  assign w_stable_chg = (w_stable != r_stable_q);

  // State register plus registered outputs and the corner timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STOP;
      r_dir        <= DIR_STOP;
      r_dir_change <= 1'b0;
      r_stable_q   <= '0;
      r_corner_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_dir        <= w_dir_next;
      r_dir_change <= (w_dir_next != r_dir);
      r_stable_q   <= w_stable;
      // Timer restarts on entry and on any change of the debounced pattern.
      if (w_state_next == ST_CORNER_HOLD && r_state == ST_CORNER_HOLD && !w_stable_chg)
        r_corner_cnt <= r_corner_cnt + CORNER_W'(1);
      else
        r_corner_cnt <= '0;
    end
  end

`ifdef LOST_RECOVER_EN
  // Recovery window timer while in LOST.
  always_ff @(posedge clk) begin
    if (rst)
      r_lost_cnt <= '0;
    else if (w_state_next == ST_LOST && r_state == ST_LOST)
      r_lost_cnt <= r_lost_cnt + LOST_W'(1);
    else
      r_lost_cnt <= '0;
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = w_decoded;
    if (!enable) begin
      w_state_next = ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: begin
          // No automatic retry of a corner that already timed out.
          if (w_decoded == ST_CORNER_HOLD) w_state_next = ST_STOP;
        end
        ST_CORNER_HOLD: begin
          if (w_decoded == ST_CORNER_HOLD && !w_stable_chg &&
              r_corner_cnt == CORNER_W'(CORNER_CYCLES - 1))
            w_state_next = ST_STOP;
        end
        ST_LOST: begin
`ifdef LOST_RECOVER_EN
          if (w_decoded == ST_LOST && r_lost_cnt == LOST_W'(LOST_CYCLES - 1))
            w_state_next = ST_STOP;
`else
          if (w_decoded == ST_CORNER_HOLD) w_state_next = ST_STOP;
`endif
        end
        default: w_state_next = w_decoded;
      endcase
    end
  end

  // Output logic: steering command for the state being entered.
  always_comb begin
    w_dir_next = DIR_STOP;
    case (w_state_next)
      ST_FOLLOW:      w_dir_next = DIR_PROCEED;
      ST_VEER_L:      w_dir_next = DIR_VEER_L;
      ST_VEER_R:      w_dir_next = DIR_VEER_R;
      ST_TURN_L:      w_dir_next = DIR_PIVOT_L;
      ST_TURN_R:      w_dir_next = DIR_PIVOT_R;
      ST_CORNER_HOLD: w_dir_next = DIR_PROCEED;
      ST_STOP:        w_dir_next = DIR_STOP;
      ST_LOST: begin
`ifdef LOST_RECOVER_EN
        // Hard turn toward the side last steered; r_dir holds it while LOST.
        if (r_state == ST_LOST)
          w_dir_next = r_dir;
        else if (r_state == ST_VEER_L || r_state == ST_TURN_L)
          w_dir_next = DIR_HARD_L;
        else if (r_state == ST_VEER_R || r_state == ST_TURN_R)
          w_dir_next = DIR_HARD_R;
        else
          w_dir_next = DIR_STOP;
`else
        w_dir_next = DIR_STOP;
`endif
      end
      default: w_dir_next = DIR_STOP;
    endcase
  end

  assign dir        = r_dir;
  assign state      = r_state;
  assign stable     = w_stable;
  assign dir_change = r_dir_change;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: directed and randomized stimulus for line_follow_ctrl,
// checked every cycle against a behavioural model, plus directed spot checks.
module tb_line_follow_ctrl;

  localparam int unsigned NP = 3;
  localparam int unsigned W  = 2 * NP;
  localparam int unsigned DB = 4;
  localparam int unsigned CC = 10;
  localparam int unsigned LC = 8;

  localparam logic [2:0] S_FOLLOW = 3'd0, S_VEER_L = 3'd1, S_VEER_R = 3'd2,
                         S_TURN_L = 3'd3, S_TURN_R = 3'd4, S_CORNER = 3'd5,
                         S_STOP   = 3'd6, S_LOST   = 3'd7;
  localparam logic [3:0] D_PROCEED = 4'b0000, D_VEER_L = 4'b0101, D_VEER_R = 4'b1001,
                         D_PIVOT_L = 4'b0111, D_PIVOT_R = 4'b1011,
                         D_HARD_L  = 4'b0110, D_HARD_R  = 4'b1010, D_STOP = 4'b1111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] sensor_n = '1;
  logic [3:0]   dir;
  logic [2:0]   state;
  logic [W-1:0] stable;
  logic         dir_change;

  int checks = 0;
  int errors = 0;
  int dc_seen = 0;

  // Behavioural model state
  int           cyc = 0;
  logic [2:0]   m_state = S_STOP;
  logic [3:0]   m_dir = D_STOP;
  logic         m_dc = 1'b0;
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_stable_prev = '0;
  logic [W-1:0] m_sync[$];
  int           m_run[W];
  int           m_ch_since = 0;
`ifdef LOST_RECOVER_EN
  int           m_lost_since = 0;
`endif

  line_follow_ctrl #(
    .N_PAIRS         (NP),
    .DEBOUNCE_CYCLES (DB),
    .CORNER_CYCLES   (CC)
`ifdef LOST_RECOVER_EN
    ,
    .LOST_CYCLES     (LC)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sensor_n   (sensor_n),
    .dir        (dir),
    .state      (state),
    .stable     (stable),
    .dir_change (dir_change)
  );

  always #5 clk = ~clk;

  // Pattern classification from the steering rules; pair 2 front, pair 1 corner.
  function automatic logic [2:0] decode(input logic [W-1:0] s);
    logic [1:0] f;
    logic [1:0] m;
    f = {s[4], s[5]};
    m = {s[2], s[3]};
    if (s == '0)                    return S_LOST;
    if (f == 2'b11)                 return S_FOLLOW;
    if (f == 2'b10)                 return S_VEER_L;
    if (f == 2'b01)                 return S_VEER_R;
    if (m == 2'b10)                 return S_TURN_L;
    if (m == 2'b01)                 return S_TURN_R;
    return S_CORNER;
  endfunction

  function automatic logic [3:0] dir_for(input logic [2:0] nxt, input logic [2:0] cur,
                                         input logic [3:0] cur_dir);
    case (nxt)
      S_FOLLOW, S_CORNER: return D_PROCEED;
      S_VEER_L:           return D_VEER_L;
      S_VEER_R:           return D_VEER_R;
      S_TURN_L:           return D_PIVOT_L;
      S_TURN_R:           return D_PIVOT_R;
      S_LOST: begin
`ifdef LOST_RECOVER_EN
        if (cur == S_LOST) return cur_dir;
        if (cur == S_VEER_L || cur == S_TURN_L) return D_HARD_L;
        if (cur == S_VEER_R || cur == S_TURN_R) return D_HARD_R;
        return D_STOP;
`else
        if (cur == S_LOST) return cur_dir;
        return D_STOP;
`endif
      end
      default: return D_STOP;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_STOP; m_dir = D_STOP; m_dc = 1'b0;
    m_stable = '0; m_stable_prev = '0;
    m_sync.delete();
    m_sync.push_back('0);
    m_sync.push_back('0);
    for (int i = 0; i < int'(W); i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [W-1:0] synced;
    logic [W-1:0] nstable;
    logic [2:0]   dec;
    logic [2:0]   nxt;
    logic [3:0]   ndir;
    logic         chg;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      dec = decode(m_stable);
      chg = (m_stable != m_stable_prev);
      if (!enable)                                  nxt = S_STOP;
      else if (m_state == S_STOP && dec == S_CORNER) nxt = S_STOP;
      else if (m_state == S_CORNER && dec == S_CORNER && !chg && (cyc - m_ch_since) == int'(CC))
        nxt = S_STOP;
`ifdef LOST_RECOVER_EN
      else if (m_state == S_LOST && dec == S_LOST && (cyc - m_lost_since) == int'(LC))
        nxt = S_STOP;
`else
      else if (m_state == S_LOST && dec == S_CORNER) nxt = S_STOP;
`endif
      else nxt = dec;
      ndir = dir_for(nxt, m_state, m_dir);
      m_dc = (ndir != m_dir);
      if (nxt == S_CORNER && (m_state != S_CORNER || chg)) m_ch_since = cyc;
`ifdef LOST_RECOVER_EN
      if (nxt == S_LOST && m_state != S_LOST) m_lost_since = cyc;
`endif
      m_dir = ndir;
      m_state = nxt;
      // Debounce: a bit follows its synchronised value after DB disagreeing samples.
      synced = m_sync.pop_front();
      m_sync.push_back(~sensor_n);
      nstable = m_stable;
      for (int i = 0; i < int'(W); i++) begin
        if (synced[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB)) begin
            nstable[i] = synced[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_stable_prev = m_stable;
      m_stable = nstable;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (dir_change === 1'b1) dc_seen++;
      chk("model_dir", 32'(dir), 32'(m_dir));
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_stable", 32'(stable), 32'(m_stable));
      chk("model_dir_change", 32'(dir_change), 32'(m_dc));
    end
  endtask

  logic [W-1:0] pats [10] = '{6'b001111, 6'b101111, 6'b011111, 6'b111011, 6'b110111,
                              6'b110011, 6'b111111, 6'b111110, 6'b000000, 6'b110010};

  initial begin
    model_reset();

    // Reset
    rst = 1'b1; enable = 1'b0; sensor_n = '1;
    step(3);
    chk("reset_dir", 32'(dir), 32'(D_STOP));
    chk("reset_state", 32'(state), 32'(S_STOP));
    chk("reset_stable", 32'(stable), 32'd0);
    chk("reset_dir_change", 32'(dir_change), 32'd0);

    // Front both line -> FOLLOW 7 cycles after release
    rst = 1'b0; enable = 1'b1; sensor_n = 6'b001111; dc_seen = 0;
    step(7);
    chk("follow_dir", 32'(dir), 32'(D_PROCEED));
    chk("follow_state", 32'(state), 32'(S_FOLLOW));
    step(5);
    chk("follow_dc_once", 32'(dc_seen), 32'd1);

    // Short glitch on front-right never reaches stable
    dc_seen = 0;
    sensor_n = 6'b101111;
    step(2);
    sensor_n = 6'b001111;
    step(10);
    chk("glitch_dir", 32'(dir), 32'(D_PROCEED));
    chk("glitch_stable", 32'(stable), 32'(6'b110000));
    chk("glitch_no_dc", 32'(dc_seen), 32'd0);

    // Front left only, then corner left
    sensor_n = 6'b101111;
    step(7);
    chk("veer_l_dir", 32'(dir), 32'(D_VEER_L));
    sensor_n = 6'b111011;
    step(7);
    chk("turn_l_dir", 32'(dir), 32'(D_PIVOT_L));

    // Corner hold times out after CC cycles
    sensor_n = 6'b110011;
    step(7);
    chk("corner_entry", 32'(state), 32'(S_CORNER));
    step(9);
    chk("corner_last", 32'(dir), 32'(D_PROCEED));
    step(1);
    chk("corner_timeout_dir", 32'(dir), 32'(D_STOP));
    chk("corner_timeout_state", 32'(state), 32'(S_STOP));

    // Corner hold restarted by a rear-pair change
    sensor_n = 6'b101111;
    step(7);
    sensor_n = 6'b110011;
    step(7);
    chk("corner2_entry", 32'(state), 32'(S_CORNER));
    sensor_n = 6'b110010;
    step(12);
    chk("corner2_restarted", 32'(state), 32'(S_CORNER));
    step(4);
    chk("corner2_last", 32'(dir), 32'(D_PROCEED));
    step(1);
    chk("corner2_timeout", 32'(dir), 32'(D_STOP));

    // VEER_R, enable drop, recovery
    sensor_n = 6'b011111;
    step(7);
    chk("veer_r_dir", 32'(dir), 32'(D_VEER_R));
    enable = 1'b0;
    step(1);
    chk("disable_dir", 32'(dir), 32'(D_STOP));
    chk("disable_state", 32'(state), 32'(S_STOP));
    enable = 1'b1;
    step(1);
    chk("reenable_dir", 32'(dir), 32'(D_VEER_R));

    // TURN_L then all sensors off -> LOST
    sensor_n = 6'b111011;
    step(7);
    chk("turn_l2_dir", 32'(dir), 32'(D_PIVOT_L));
    sensor_n = 6'b111111;
    step(7);
    chk("lost_state", 32'(state), 32'(S_LOST));
`ifdef LOST_RECOVER_EN
    chk("lost_dir", 32'(dir), 32'(D_HARD_L));
    step(7);
    chk("lost_window_end", 32'(dir), 32'(D_HARD_L));
    step(1);
    chk("lost_expired", 32'(dir), 32'(D_STOP));
    chk("lost_expired_state", 32'(state), 32'(S_STOP));
`else
    chk("lost_dir", 32'(dir), 32'(D_STOP));
    step(8);
    chk("lost_hold_state", 32'(state), 32'(S_LOST));
`endif

    // Mid-operation reset
    sensor_n = 6'b001111;
    step(8);
    rst = 1'b1;
    step(1);
    chk("midrst_dir", 32'(dir), 32'(D_STOP));
    chk("midrst_state", 32'(state), 32'(S_STOP));
    chk("midrst_stable", 32'(stable), 32'd0);
    rst = 1'b0;

    // Randomized segments
    for (int seg = 0; seg < 110; seg++) begin
      if ($urandom_range(0, 3) == 0) sensor_n = W'($urandom);
      else sensor_n = pats[$urandom_range(0, 9)];
      enable = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 39) == 0);
      step(1);
      rst = 1'b0;
      enable = 1'b1;
      step(int'($urandom_range(1, 28)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
